coin_pulse_conditioner: RTL
===========================

# coin_pulse_conditioner

Front end of the vending-machine controller. Turns the raw, asynchronous, bouncy dime and nickel slot sensors into clean, synchronous, single-cycle D and N pulses for the coin-accumulator FSM. Two pulses are never emitted in the same cycle, and a programmable idle gap separates consecutive pulses. The accumulator is not defined for D=N=1 or for a coin arriving in its 15c/20c payout states, and this block guarantees neither condition reaches it.

## Interface
- DB_CYCLES, 4: consecutive synchronized cycles a raw level must hold before it is accepted (≥2).
- GAP, 1: forced idle cycles after every emitted pulse (≥1).
- Clock  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high. Clears all state on the rising edge of Clock where it is high.
- DimeRaw  in  1  asynchronous dime-sensor level; high while a coin is in the slot.
- NickelRaw  in  1  asynchronous nickel-sensor level.
- D  out  1  one-cycle dime pulse to the accumulator.
- N  out  1  one-cycle nickel pulse to the accumulator.
- Lost  out  1  sticky flag: a coin edge was dropped. Cleared only by Reset.

## Operation
- Per channel, a 2-FF synchronizer (s1, s2) feeds a debouncer.
  - Debouncer holds `stable` and a counter.
  - If s2 ≠ stable, counter increments. When the counter equals DB_CYCLES-1, `stable` takes s2 and the counter clears.
  - If s2 = stable, the counter clears. Any glitch restarts the count.
- On the edge where `stable` goes 0→1, that channel's `pending` bit is set. A 1→0 transition produces nothing.
- Arbiter/emitter, gap counter `gcnt`:
  - If gcnt = 0 and any pending bit is set, emit one pulse. Dime has priority over nickel.
  - The emitted channel's pending bit clears, and gcnt loads GAP.
  - Otherwise, gcnt decrements while nonzero.
  - D and N are registered outputs and are never simultaneously 1.
- Pending set while already set: that edge is dropped and Lost goes to 1. Exception: on the same edge as that channel's emission, the new set wins and pending stays 1 with no loss.
- Reset: every synchronizer, stable, counter, pending bit, gcnt, D, N and Lost goes to 0.
  - Coins in flight at reset are discarded.
  - A sensor still high after reset is treated as a new rising level and yields one pulse after normal debounce.

## Timing
- Reset values: D=0, N=0, Lost=0.
- Latency (uncontested channel, gcnt=0): edge 0 is the first edge sampling Raw=1.
  - s2=1 at edge 1.
  - stable and pending set at edge DB_CYCLES+1.
  - Pulse high during the cycle after edge DB_CYCLES+2, i.e. edge 6 with defaults.
- Pulse width is exactly 1 cycle.
- Minimum spacing between pulse edges is GAP+1 cycles.
- Simultaneous dime/nickel acceptance: D at edge k, N at edge k+GAP+1.
- Raw pulse shorter than DB_CYCLES synchronized cycles: no output.
- Held level: exactly one pulse, regardless of duration.

## Test plan
- Clean dime, defaults: DimeRaw 0→1 sampled at edge 0 and held 20 cycles → D=1 only after edge 6, D=0 after edge 7. N, Lost stay 0.
- Simultaneous coins, defaults: DimeRaw and NickelRaw rise together → D after edge 6, N after edge 8, never both high.
- Bounce: NickelRaw high 3 cycles, low 1, high 3, low → no N pulse. Then high 10 cycles → exactly one N pulse, 6 edges after that rise.
- Overflow, GAP=30: dime accepted, then NickelRaw high 6 / low 6 twice within the gap → first nickel pends, second sets Lost=1. Exactly one N after gcnt expires, and Lost stays 1.
- Reset mid-operation: assert Reset on the edge pending is set for a dime → no D pulse, all outputs 0. With DimeRaw still high, release Reset → D pulse 6 edges after the first post-reset sampling edge.
- Long hold, defaults: DimeRaw high 100 cycles then low 100 → exactly one D pulse total.

Source files
------------

// File: rtl/coin_pulse_conditioner.sv
// Coin sensor front end: synchronizes and debounces the dime and nickel slot sensors,
// then spaces accepted coin edges into single-cycle D/N pulses that never overlap.
module coin_pulse_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int GAP       = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic DimeRaw,
    input  logic NickelRaw,
    output logic D,
    output logic N,
    output logic Lost
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

    // Channel 0 is the dime, channel 1 the nickel; the dime wins arbitration.
    logic [1:0]    raw;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    stable;
    logic [CW-1:0] cnt [2];
    logic [1:0]    rise;
    logic [1:0]    pending;
    logic [GW-1:0] gcnt;
    logic          ready;
    logic          emit_d;
    logic          emit_n;
    logic          drop;

    assign raw = {NickelRaw, DimeRaw};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int ch = 0; ch < 2; ch++) begin
                if (s2[ch] != stable[ch]) begin
                    if (cnt[ch] == CNT_LAST) begin
                        stable[ch] <= s2[ch];
                        cnt[ch]    <= '0;
                    end else begin
                        cnt[ch] <= cnt[ch] + 1'b1;
                    end
                end else begin
                    cnt[ch] <= '0;
                end
            end
        end
    end

    // A coin edge is the cycle the debouncer accepts a new high level.
    always_comb begin
        rise = '0;
        for (int ch = 0; ch < 2; ch++) begin
            rise[ch] = s2[ch] && !stable[ch] && (cnt[ch] == CNT_LAST);
        end
    end

    assign ready  = (gcnt == '0);
    assign emit_d = ready && pending[0];
    assign emit_n = ready && !pending[0] && pending[1];

    // A new edge landing on a still-pending coin is lost, unless that coin leaves this cycle.
    assign drop = (rise[0] && pending[0] && !emit_d) ||
                  (rise[1] && pending[1] && !emit_n);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pending <= '0;
            gcnt    <= '0;
            D       <= 1'b0;
            N       <= 1'b0;
            Lost    <= 1'b0;
        end else begin
            D <= emit_d;
            N <= emit_n;

            if (emit_d || emit_n) begin
                gcnt <= GAP_LOAD;
            end else if (gcnt != '0) begin
                gcnt <= gcnt - 1'b1;
            end

            if (emit_d) begin
                pending[0] <= rise[0];
            end else if (rise[0]) begin
                pending[0] <= 1'b1;
            end

            if (emit_n) begin
                pending[1] <= rise[1];
            end else if (rise[1]) begin
                pending[1] <= 1'b1;
            end

            if (drop) begin
                Lost <= 1'b1;
            end
        end
    end

endmodule
